// File: rtl/toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_rx
// Brief    : Two-phase toggle handshake receiver feeding a FWFT FIFO.
// Revision : 1.0
// ============================================================================
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       req_tgl,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       ack_tgl,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                event_cnt,
  output logic                       protocol_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   ack_q, ack_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic toggle_seen;
  logic push;
  logic pop;
  logic space;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], req_tgl};
    prev_d      = sync_q[SYNC_STAGES-1];
    toggle_seen = sync_q[SYNC_STAGES-1] ^ prev_q;
    pop         = (level_q != '0) && out_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    space       = (level_q < FULL_LVL) || pop;
    push        = 1'b0;
    state_d     = state_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (toggle_seen) begin
          if (space) push = 1'b1;
          else       state_d = STALL;
        end
      end
      STALL: begin
        // Sender flipped again before being acknowledged.
        if (toggle_seen) err_d = 1'b1;
        if (space) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ack_d    = ack_q ^ push;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = push ? cnt_q + 16'd1 : cnt_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_data;
  end

  assign ack_tgl      = ack_q;
  assign out_data     = mem_q[rd_ptr_q];
  assign out_valid    = (level_q != '0);
  assign level        = level_q;
  assign event_cnt    = cnt_q;
  assign protocol_err = err_q;

endmodule
`default_nettype wire
